// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable thresholds,
// overflow/underflow pulses and selectable first-word-fall-through read mode.
module sync_fifo_param #(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned AF_THRESH  = DEPTH - 2,
  parameter  int unsigned AE_THRESH  = 2,
  parameter  bit          FWFT       = 1'b0,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] head;
  logic             unused_wrap;

  assign head = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  // Wrap bits only distinguish full from empty; occupancy is tracked by count.
  assign unused_wrap = wr_ptr_q[ADDR_WIDTH] ^ rd_ptr_q[ADDR_WIDTH];

  always_comb begin
    wr_acc   = wr_en_i && !full_q;
    rd_acc   = rd_en_i && !empty_q;
    wr_ptr_d = wr_ptr_q + CW'(wr_acc);
    rd_ptr_d = rd_ptr_q + CW'(rd_acc);
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    af_d     = (count_d >= CW'(AF_THRESH));
    ae_d     = (count_d <= CW'(AE_THRESH));
    ovf_d    = wr_en_i && full_q;
    udf_d    = rd_en_i && empty_q;
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? head : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !rst_i) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    if (FWFT) begin
      rdata_o  = empty_q ? '0 : head;
      rvalid_o = !empty_q;
    end else begin
      rdata_o  = rdata_q;
      rvalid_o = rvalid_q;
    end
  end

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule
